// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions: fetch state encoding and default datapath widths.
package instruction_fetch_pkg;

   // Default address/instruction widths, shared with the program counter.
   localparam int unsigned FETCH_AW = 16;
   localparam int unsigned FETCH_DW = 16;

   // Fetch sequencer states.
   typedef enum logic [2:0] {
      FS_IDLE     = 3'd0,
      FS_ADDR     = 3'd1,
      FS_WAIT     = 3'd2,
      FS_HOLD     = 3'd3,
      FS_REDIRECT = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch sequencer: captures the PC, runs a req/ack memory read, holds the
// returned word in IR for the decoder and steers the PC (increment/branch).
// Every output is a flop; next values are derived from the next state.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int unsigned AW = FETCH_AW,
   parameter int unsigned DW = FETCH_DW
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic [AW-1:0] PC_Q,
   output logic          PC_EN,
   output logic          PC_INC,
   output logic          PC_LOAD,
   output logic [AW-1:0] PC_D,
   output logic          MEM_REQ,
   output logic [AW-1:0] MEM_ADDR,
   input  logic          MEM_ACK,
   input  logic [DW-1:0] MEM_RDATA,
   output logic [DW-1:0] IR,
   output logic          IR_VALID,
   input  logic          IR_READY,
   input  logic          BRANCH,
   input  logic [AW-1:0] BRANCH_TARGET,
   input  logic          HALT
);

   fetch_state_t  state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] ir_q, ir_d;
   logic          ir_valid_q, ir_valid_d;
   logic          pend_q, pend_d;
   logic [AW-1:0] tgt_q, tgt_d;
   logic          pc_en_q, pc_en_d;
   logic          pc_inc_q, pc_inc_d;
   logic          pc_load_q, pc_load_d;
   logic [AW-1:0] pc_d_q, pc_d_d;
   logic          mem_req_q, mem_req_d;
   logic          branch_pend;

   // State, datapath and output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= FS_IDLE;
         addr_q     <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         pend_q     <= 1'b0;
         tgt_q      <= '0;
         pc_en_q    <= 1'b0;
         pc_inc_q   <= 1'b0;
         pc_load_q  <= 1'b0;
         pc_d_q     <= '0;
         mem_req_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         pend_q     <= pend_d;
         tgt_q      <= tgt_d;
         pc_en_q    <= pc_en_d;
         pc_inc_q   <= pc_inc_d;
         pc_load_q  <= pc_load_d;
         pc_d_q     <= pc_d_d;
         mem_req_q  <= mem_req_d;
      end
   end

   // Next state, branch bookkeeping and next output values.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      ir_d        = ir_q;
      pend_d      = pend_q;
      tgt_d       = tgt_q;
      pc_d_d      = pc_d_q;
      branch_pend = pend_q | BRANCH;

      // A new branch always overwrites the target: the last one wins.
      if (BRANCH) begin
         pend_d = 1'b1;
         tgt_d  = BRANCH_TARGET;
      end

      case (state_q)
         FS_IDLE: begin
            if (branch_pend) begin
               state_d = FS_REDIRECT;
            end else if (!HALT) begin
               state_d = FS_ADDR;
            end
         end
         FS_ADDR: begin
            if (branch_pend) begin
               state_d = FS_REDIRECT;
            end else begin
               addr_d  = PC_Q;
               state_d = FS_WAIT;
            end
         end
         FS_WAIT: begin
            // An outstanding read is always completed; a pending branch
            // only decides whether its data is kept.
            if (MEM_ACK) begin
               if (branch_pend) begin
                  state_d = FS_REDIRECT;
               end else begin
                  ir_d    = MEM_RDATA;
                  state_d = FS_HOLD;
               end
            end
         end
         FS_HOLD: begin
            if (branch_pend) begin
               state_d = FS_REDIRECT;
            end else if (IR_READY) begin
               state_d = HALT ? FS_IDLE : FS_ADDR;
            end
         end
         FS_REDIRECT: begin
            // The pending branch is consumed here unless a fresh one arrives.
            pend_d = BRANCH;
            if (BRANCH) begin
               state_d = FS_REDIRECT;
            end else begin
               state_d = HALT ? FS_IDLE : FS_ADDR;
            end
         end
         default: begin
            state_d = FS_IDLE;
         end
      endcase

      if (state_d == FS_REDIRECT) begin
         pc_d_d = tgt_d;
      end

      pc_en_d    = (state_d == FS_ADDR);
      mem_req_d  = (state_d == FS_WAIT);
      ir_valid_d = (state_d == FS_HOLD);
      pc_inc_d   = (state_q == FS_WAIT) && (state_d == FS_HOLD);
      pc_load_d  = (state_d == FS_REDIRECT);
   end

   assign PC_EN    = pc_en_q;
   assign PC_INC   = pc_inc_q;
   assign PC_LOAD  = pc_load_q;
   assign PC_D     = pc_d_q;
   assign MEM_REQ  = mem_req_q;
   assign MEM_ADDR = addr_q;
   assign IR       = ir_q;
   assign IR_VALID = ir_valid_q;

endmodule
